// File: rtl/rtf65002_ifetch8.sv
// Byte-queue instruction fetch sequencer for 8-bit emulation mode: fills a circular byte
// queue from aligned 32-bit bus reads and presents one complete instruction per handshake.
module rtf65002_ifetch8 #(
  parameter int          QDEPTH = 8,
  parameter logic [31:0] RST_PC = 32'h0000F000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        cyc_o,
  output logic [31:0] adr_o,
  input  logic        ack_i,
  input  logic [31:0] dat_i,
  input  logic [2:0]  ilen_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] ins_o,
  output logic [31:0] pc_o,
  input  logic        jmp_i,
  input  logic [31:0] jadr_i
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QD = CW'(QDEPTH);
  localparam logic [CW-1:0] WORD_BYTES = CW'(4);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e         state_q, state_d;
  logic           cyc_q, cyc_d;
  logic [31:0]    adr_q, adr_d;
  logic [31:0]    pc_q, pc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  rd_q, rd_d;
  logic [PW-1:0]  wr_q, wr_d;
  logic [1:0]     skip_q, skip_d;
  logic [7:0]     mem_q [QDEPTH];

  logic           wr_en;
  logic           take;
  logic [2:0]     len;
  logic [CW-1:0]  fill;

  // NOTE: every signal written here gets a default first, so no path can leave one
  // unassigned and infer a latch; comb logic uses blocking '=', flops use '<=' only.
  always_comb begin
    len     = (ilen_i == 3'd0) ? 3'd1 : ilen_i;
    valid_o = (count_q >= CW'(len)) && (state_q != DRAIN);
    take    = valid_o && ready_i;
    fill    = CW'(3'd4 - {1'b0, skip_q});

    state_d = state_q;
    adr_d   = adr_q;
    pc_d    = pc_q;
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    skip_d  = skip_q;
    wr_en   = 1'b0;

    if (take) begin
      rd_d    = rd_q + PW'(len);
      count_d = count_q - CW'(len);
      pc_d    = pc_q + 32'(len);
    end

    if (jmp_i) begin
      // Flush overrides any same-cycle consume or returned data.
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      pc_d    = jadr_i;
      adr_d   = {jadr_i[31:2], 2'b00};
      skip_d  = jadr_i[1:0];
      state_d = (state_q == IDLE || ack_i) ? IDLE : DRAIN;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (QD - count_q >= WORD_BYTES) state_d = FETCH;
        end
        FETCH: begin
          if (ack_i) begin
            wr_en   = 1'b1;
            wr_d    = wr_q + PW'(fill);
            count_d = count_d + fill;
            skip_d  = 2'b00;
            adr_d   = adr_q + 32'd4;
            state_d = (QD - count_d >= WORD_BYTES) ? FETCH : IDLE;
          end
        end
        DRAIN: begin
          if (ack_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    cyc_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      adr_q   <= {RST_PC[31:2], 2'b00};
      pc_q    <= RST_PC;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      skip_q  <= RST_PC[1:0];
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      skip_q  <= skip_d;
    end
  end

  // NOTE: queue storage is not reset; count/pointers alone decide which bytes are live.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (2'(k) >= skip_q)
          mem_q[wr_q + PW'(k) - PW'(skip_q)] <= dat_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++)
      ins_o[8*k +: 8] = mem_q[rd_q + PW'(k)];
  end

  assign cyc_o = cyc_q;
  assign adr_o = adr_q;
  assign pc_o  = pc_q;

endmodule

// File: tb/tb_rtf65002_ifetch8.sv
// Directed bench for rtf65002_ifetch8: reset, streaming, straddling instructions,
// redirect during an outstanding cycle, queue-full throttling and simultaneous consume/fill.
module tb_rtf65002_ifetch8;

  logic        clk_i;
  logic        rst_i;
  logic        cyc_o;
  logic [31:0] adr_o;
  logic        ack_i;
  logic [31:0] dat_i;
  logic [2:0]  ilen_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] ins_o;
  logic [31:0] pc_o;
  logic        jmp_i;
  logic [31:0] jadr_i;

  int checks = 0;
  int errors = 0;

  rtf65002_ifetch8 #(.QDEPTH(8), .RST_PC(32'h0000F000)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_o(cyc_o), .adr_o(adr_o), .ack_i(ack_i),
    .dat_i(dat_i), .ilen_i(ilen_i), .valid_o(valid_o), .ready_i(ready_i),
    .ins_o(ins_o), .pc_o(pc_o), .jmp_i(jmp_i), .jadr_i(jadr_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Bus word for a given address: byte k holds adr[7:0]+k.
  function automatic logic [31:0] word_for(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; jmp_i = 1'b0; jadr_i = '0; ack_i = 1'b0; dat_i = '0;
    ready_i = 1'b0; ilen_i = 3'd1;
    step(); step();
    checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %0b want 0", cyc_o); end
    checks++; if (adr_o !== 32'h0000F000) begin errors++; $display("FAIL reset_adr: got %h want 0000f000", adr_o); end
    checks++; if (pc_o !== 32'h0000F000) begin errors++; $display("FAIL reset_pc: got %h want 0000f000", pc_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
    rst_i = 1'b0;
    step(); step();
    checks++; if (cyc_o !== 1'b1) begin errors++; $display("FAIL reset_req_cyc: got %0b want 1", cyc_o); end
    checks++; if (adr_o !== 32'h0000F000) begin errors++; $display("FAIL reset_req_adr: got %h want 0000f000", adr_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_noack_valid: got %0b want 0", valid_o); end
  endtask

  task automatic test_stream();
    ready_i = 1'b1; ilen_i = 3'd1; dat_i = 32'hEAEAEAEA; ack_i = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      ack_i = (i == 0);
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, valid_o); end
      checks++; if (pc_o !== 32'h0000F000 + i) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, pc_o, 32'h0000F000 + i); end
      checks++; if (ins_o[7:0] !== 8'hEA) begin errors++; $display("FAIL stream_op[%0d]: got %h want ea", i, ins_o[7:0]); end
      step();
    end
    ack_i = 1'b0; ready_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stream_empty_valid: got %0b want 0", valid_o); end
    checks++; if (pc_o !== 32'h0000F008) begin errors++; $display("FAIL stream_end_pc: got %h want 0000f008", pc_o); end
    checks++; if (cyc_o !== 1'b1 || adr_o !== 32'h0000F008) begin errors++; $display("FAIL stream_next_req: got cyc %0b adr %h want 1 0000f008", cyc_o, adr_o); end
  endtask

  task automatic test_straddle();
    jmp_i = 1'b1; jadr_i = 32'h0000F003;
    step();
    jmp_i = 1'b0;
    checks++; if (cyc_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL straddle_drain: got cyc %0b valid %0b want 1 0", cyc_o, valid_o); end
    ack_i = 1'b1; dat_i = 32'h11223344;
    step();
    ack_i = 1'b0;
    step();
    checks++; if (cyc_o !== 1'b1 || adr_o !== 32'h0000F000) begin errors++; $display("FAIL straddle_req: got cyc %0b adr %h want 1 0000f000", cyc_o, adr_o); end
    ilen_i = 3'd3; ack_i = 1'b1; dat_i = 32'hAB000000;
    step();
    ack_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL straddle_partial_valid: got %0b want 0", valid_o); end
    checks++; if (pc_o !== 32'h0000F003) begin errors++; $display("FAIL straddle_pc: got %h want 0000f003", pc_o); end
    ack_i = 1'b1; dat_i = 32'h99332211;
    step();
    ack_i = 1'b0;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL straddle_full_valid: got %0b want 1", valid_o); end
    checks++; if (ins_o[23:0] !== 24'h2211AB) begin errors++; $display("FAIL straddle_ins: got %h want 2211ab", ins_o[23:0]); end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0; ilen_i = 3'd1;
    checks++; if (pc_o !== 32'h0000F006 || ins_o[7:0] !== 8'h33) begin errors++; $display("FAIL straddle_next: got pc %h op %h want 0000f006 33", pc_o, ins_o[7:0]); end
  endtask

  task automatic test_jump_drain();
    step();
    checks++; if (cyc_o !== 1'b1) begin errors++; $display("FAIL jump_pre_cyc: got %0b want 1", cyc_o); end
    jmp_i = 1'b1; jadr_i = 32'h00001202;
    step();
    jmp_i = 1'b0;
    step();
    checks++; if (cyc_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL jump_drain: got cyc %0b valid %0b want 1 0", cyc_o, valid_o); end
    checks++; if (adr_o !== 32'h00001200 || pc_o !== 32'h00001202) begin errors++; $display("FAIL jump_target: got adr %h pc %h want 00001200 00001202", adr_o, pc_o); end
    ack_i = 1'b1; dat_i = 32'hDEADBEEF;
    step();
    ack_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL jump_discard_valid: got %0b want 0", valid_o); end
    step();
    checks++; if (cyc_o !== 1'b1 || adr_o !== 32'h00001200) begin errors++; $display("FAIL jump_refetch: got cyc %0b adr %h want 1 00001200", cyc_o, adr_o); end
    ack_i = 1'b1; dat_i = 32'h44332211;
    step();
    ack_i = 1'b0;
    checks++; if (valid_o !== 1'b1 || ins_o[7:0] !== 8'h33 || pc_o !== 32'h00001202) begin errors++; $display("FAIL jump_first: got valid %0b op %h pc %h want 1 33 00001202", valid_o, ins_o[7:0], pc_o); end
    ilen_i = 3'd2; #1;
    checks++; if (valid_o !== 1'b1 || ins_o[15:0] !== 16'h4433) begin errors++; $display("FAIL jump_len2: got valid %0b ins %h want 1 4433", valid_o, ins_o[15:0]); end
    ilen_i = 3'd3; #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL jump_len3_valid: got %0b want 0", valid_o); end
    ilen_i = 3'd0; #1;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL jump_len0_valid: got %0b want 1", valid_o); end
    ilen_i = 3'd1;
  endtask

  task automatic test_full();
    int acks;
    rst_i = 1'b1; jmp_i = 1'b1; jadr_i = 32'h00005555;
    step();
    rst_i = 1'b0; jmp_i = 1'b0;
    checks++; if (pc_o !== 32'h0000F000) begin errors++; $display("FAIL full_rst_beats_jmp: got %h want 0000f000", pc_o); end
    step();
    acks = 0;
    for (int n = 0; n < 6; n++) begin
      ack_i = cyc_o;
      dat_i = word_for(adr_o);
      if (cyc_o) acks++;
      step();
    end
    ack_i = 1'b0;
    checks++; if (acks !== 2) begin errors++; $display("FAIL full_ack_count: got %0d want 2", acks); end
    checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL full_withheld: got %0b want 0", cyc_o); end
    ilen_i = 3'd4; ready_i = 1'b1; #1;
    checks++; if (valid_o !== 1'b1 || ins_o !== 32'h03020100 || pc_o !== 32'h0000F000) begin errors++; $display("FAIL full_first: got valid %0b ins %h pc %h want 1 03020100 0000f000", valid_o, ins_o, pc_o); end
    step();
    ready_i = 1'b0;
    checks++; if (ins_o !== 32'h07060504 || pc_o !== 32'h0000F004) begin errors++; $display("FAIL full_second: got ins %h pc %h want 07060504 0000f004", ins_o, pc_o); end
  endtask

  task automatic test_back_to_back();
    step();
    checks++; if (cyc_o !== 1'b1 || adr_o !== 32'h0000F008) begin errors++; $display("FAIL b2b_req: got cyc %0b adr %h want 1 0000f008", cyc_o, adr_o); end
    ilen_i = 3'd1; ready_i = 1'b1; ack_i = 1'b1; dat_i = word_for(adr_o);
    step();
    ack_i = 1'b0; ready_i = 1'b0; ilen_i = 3'd4;
    checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL b2b_withheld: got %0b want 0", cyc_o); end
    checks++; if (pc_o !== 32'h0000F005 || ins_o !== 32'h08070605) begin errors++; $display("FAIL b2b_head: got pc %h ins %h want 0000f005 08070605", pc_o, ins_o); end
    step();
    checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL b2b_still_withheld: got %0b want 0", cyc_o); end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    checks++; if (valid_o !== 1'b0 || pc_o !== 32'h0000F009) begin errors++; $display("FAIL b2b_remaining4: got valid %0b pc %h want 0 0000f009", valid_o, pc_o); end
    ilen_i = 3'd3; #1;
    checks++; if (valid_o !== 1'b1 || ins_o[23:0] !== 24'h0B0A09) begin errors++; $display("FAIL b2b_remaining3: got valid %0b ins %h want 1 0b0a09", valid_o, ins_o[23:0]); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_straddle();
    test_jump_drain();
    test_full();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
